// File: rtl/output_vc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : output_vc_arbiter
// Description : Two-VC output port arbiter. It fills the VC that is not
//               selected by polarity and drains the VC that polarity selects.
// Revision    : 1.0 - initial release
// ============================================================================
module output_vc_arbiter #(
    parameter int PACKET_WIDTH = 64,
    parameter int NUM_REQ      = 3
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic                            polarity,
    input  logic [NUM_REQ-1:0]              req_even,
    input  logic [NUM_REQ-1:0]              req_odd,
    input  logic [NUM_REQ*PACKET_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]              grant_even,
    output logic [NUM_REQ-1:0]              grant_odd,
    input  logic                            ri,
    output logic                            so,
    output logic [PACKET_WIDTH-1:0]         dout
);

    localparam int c_PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NUM_REQ-1:0] c_ONE = {{(NUM_REQ-1){1'b0}}, 1'b1};

    logic [PACKET_WIDTH-1:0] r_buf [2];
    logic [1:0]              r_full;
    logic [c_PTR_W-1:0]      r_ptr [2];
    logic                    r_so;
    logic [PACKET_WIDTH-1:0] r_dout;

    logic                    w_fill;
    logic                    w_drain;
    logic [NUM_REQ-1:0]      w_req;
    logic [NUM_REQ-1:0]      w_req_hi;
    logic [NUM_REQ-1:0]      w_pick;
    logic [NUM_REQ-1:0]      w_grant;
    logic [c_PTR_W-1:0]      w_next_ptr;
    logic [PACKET_WIDTH-1:0] w_fill_data;

    assign w_fill  = ~polarity;
    assign w_drain = polarity;
    assign w_req   = polarity ? req_even : req_odd;

    // Round robin: prefer requesters at or above the pointer, else wrap to the lowest.
    always_comb begin
        w_req_hi = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_req_hi[i] = w_req[i] && (c_PTR_W'(i) >= r_ptr[w_fill]);
        end
        w_pick  = (|w_req_hi) ? w_req_hi : w_req;
        w_grant = '0;
        if (reset && !r_full[w_fill]) begin
            w_grant = w_pick & (~w_pick + c_ONE);
        end
    end

    always_comb begin
        w_next_ptr  = '0;
        w_fill_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_next_ptr  = (i == NUM_REQ - 1) ? '0 : c_PTR_W'(i + 1);
                w_fill_data = req_data[i*PACKET_WIDTH +: PACKET_WIDTH];
            end
        end
    end

    assign grant_even = w_fill ? '0 : w_grant;
    assign grant_odd  = w_fill ? w_grant : '0;
    assign so         = r_so;
    assign dout       = r_dout;

    // Fill and drain always target opposite VCs, so both may act on one edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_full   <= 2'b00;
            r_ptr[0] <= '0;
            r_ptr[1] <= '0;
            r_buf[0] <= '0;
            r_buf[1] <= '0;
            r_so     <= 1'b0;
            r_dout   <= '0;
        end else begin
            r_so <= 1'b0;
            if (r_full[w_drain] && ri) begin
                r_so            <= 1'b1;
                r_dout          <= r_buf[w_drain];
                r_full[w_drain] <= 1'b0;
            end
            if (|w_grant) begin
                r_buf[w_fill]  <= w_fill_data;
                r_full[w_fill] <= 1'b1;
                r_ptr[w_fill]  <= w_next_ptr;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_output_vc_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_output_vc_arbiter
// Description : Directed scoreboard bench for output_vc_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_output_vc_arbiter;

    localparam int c_PW = 64;
    localparam int c_NR = 3;

    logic                 clk;
    logic                 reset;
    logic                 polarity;
    logic [c_NR-1:0]      req_even;
    logic [c_NR-1:0]      req_odd;
    logic [c_NR*c_PW-1:0] req_data;
    logic [c_NR-1:0]      grant_even;
    logic [c_NR-1:0]      grant_odd;
    logic                 ri;
    logic                 so;
    logic [c_PW-1:0]      dout;

    int checks   = 0;
    int failures = 0;
    logic [c_PW-1:0] exp_q [$];

    output_vc_arbiter #(.PACKET_WIDTH(c_PW), .NUM_REQ(c_NR)) dut (
        .clk        (clk),
        .reset      (reset),
        .polarity   (polarity),
        .req_even   (req_even),
        .req_odd    (req_odd),
        .req_data   (req_data),
        .grant_even (grant_even),
        .grant_odd  (grant_odd),
        .ri         (ri),
        .so         (so),
        .dout       (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [c_PW-1:0] obs, input logic [c_PW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive at negedge, check grants, then check so/dout after posedge.
    task automatic step(input string tag, input logic pol, input logic [2:0] re,
                        input logic [2:0] ro, input logic r, input logic [2:0] ege,
                        input logic [2:0] ego, input logic eso, input logic push);
        logic [c_PW-1:0] e;
        @(negedge clk);
        polarity = pol;
        req_even = re;
        req_odd  = ro;
        ri       = r;
        #1;
        chk({tag, ".grant_even"}, c_PW'(grant_even), c_PW'(ege));
        chk({tag, ".grant_odd"},  c_PW'(grant_odd),  c_PW'(ego));
        if (push) begin
            for (int i = 0; i < c_NR; i++) begin
                if (ege[i] || ego[i]) exp_q.push_back(req_data[i*c_PW +: c_PW]);
            end
        end
        @(posedge clk);
        #1;
        chk({tag, ".so"}, c_PW'(so), c_PW'(eso));
        if (eso && so) begin
            if (exp_q.size() == 0) begin
                chk({tag, ".dout_unexpected"}, dout, '0);
            end else begin
                e = exp_q.pop_front();
                chk({tag, ".dout"}, dout, e);
            end
        end
    endtask

    initial begin
        reset    = 1'b0;
        polarity = 1'b1;
        req_even = 3'b111;
        req_odd  = 3'b000;
        ri       = 1'b1;
        req_data = {64'hCCCC_0000_0000_000C, 64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A};

        #2;
        chk("rst.grant_even", c_PW'(grant_even), '0);
        chk("rst.grant_odd",  c_PW'(grant_odd),  '0);
        chk("rst.so",         c_PW'(so),         '0);
        chk("rst.dout",       dout,              '0);
        @(posedge clk);
        #2;
        reset = 1'b1;

        // First grant in first cycle out of reset, then drain A.
        step("first",  1'b1, 3'b111, 3'b000, 1'b1, 3'b001, 3'b000, 1'b0, 1'b1);
        step("drainA", 1'b0, 3'b111, 3'b000, 1'b1, 3'b000, 3'b000, 1'b1, 1'b0);
        // Round robin with wrap.
        step("rrB",    1'b1, 3'b111, 3'b000, 1'b1, 3'b010, 3'b000, 1'b0, 1'b1);
        step("drainB", 1'b0, 3'b111, 3'b000, 1'b1, 3'b000, 3'b000, 1'b1, 1'b0);
        step("rrC",    1'b1, 3'b111, 3'b000, 1'b1, 3'b100, 3'b000, 1'b0, 1'b1);
        step("drainC", 1'b0, 3'b111, 3'b000, 1'b1, 3'b000, 3'b000, 1'b1, 1'b0);
        step("rrwrap", 1'b1, 3'b111, 3'b000, 1'b1, 3'b001, 3'b000, 1'b0, 1'b1);
        step("drainW", 1'b0, 3'b111, 3'b000, 1'b1, 3'b000, 3'b000, 1'b1, 1'b0);
        // Full VC0 blocks a second grant in the same phase.
        step("fill2",  1'b1, 3'b111, 3'b000, 1'b1, 3'b010, 3'b000, 1'b0, 1'b1);
        step("blk0",   1'b1, 3'b111, 3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
        step("drain2", 1'b0, 3'b000, 3'b000, 1'b1, 3'b000, 3'b000, 1'b1, 1'b0);

        // VC1 back-pressure: D held through 4 odd phases with ri=0.
        req_data = {64'h3333_0000_0000_0003, 64'hDDDD_0000_0000_000D, 64'h1111_0000_0000_0001};
        step("fillD",  1'b0, 3'b000, 3'b010, 1'b1, 3'b000, 3'b010, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step("holdOdd",  1'b1, 3'b000, 3'b001, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
            step("holdEven", 1'b0, 3'b000, 3'b001, 1'b0, 3'b000, 3'b000, 1'b0, 1'b0);
        end
        step("drainD", 1'b1, 3'b000, 3'b000, 1'b1, 3'b000, 3'b000, 1'b1, 1'b0);
        step("onePls", 1'b1, 3'b000, 3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
        step("fillE",  1'b0, 3'b000, 3'b001, 1'b1, 3'b000, 3'b001, 1'b0, 1'b1);
        step("drainE", 1'b1, 3'b000, 3'b000, 1'b1, 3'b000, 3'b000, 1'b1, 1'b0);

        // Polarity toggling every cycle: alternate fill and drain on both VCs.
        req_data = {64'h5555_0000_0000_0005, 64'h4444_0000_0000_0004, 64'h6666_0000_0000_0006};
        for (int k = 0; k < 6; k++) begin
            if (k % 2 == 0)
                step("toggle", 1'b1, 3'b100, 3'b001, 1'b1, 3'b100, 3'b000, (k > 0), 1'b1);
            else
                step("toggle", 1'b0, 3'b100, 3'b001, 1'b1, 3'b000, 3'b001, 1'b1, 1'b1);
        end
        step("tglTail", 1'b1, 3'b000, 3'b000, 1'b1, 3'b000, 3'b000, 1'b1, 1'b0);

        // Fill both VCs, then reset mid-cycle: contents must be discarded.
        req_data = {64'h9999_0000_0000_0009, 64'h8888_0000_0000_0008, 64'h7777_0000_0000_0007};
        step("full0", 1'b1, 3'b001, 3'b000, 1'b0, 3'b001, 3'b000, 1'b0, 1'b0);
        step("full1", 1'b0, 3'b000, 3'b010, 1'b0, 3'b000, 3'b010, 1'b0, 1'b0);
        @(negedge clk);
        polarity = 1'b0;
        req_odd  = 3'b001;
        req_even = 3'b000;
        ri       = 1'b1;
        #1;
        reset = 1'b0;
        #1;
        chk("midrst.so",         c_PW'(so),         '0);
        chk("midrst.dout",       dout,              '0);
        chk("midrst.grant_even", c_PW'(grant_even), '0);
        chk("midrst.grant_odd",  c_PW'(grant_odd),  '0);
        @(posedge clk);
        #1;
        chk("midrst.so_edge", c_PW'(so), '0);
        #1;
        reset = 1'b1;
        step("post0", 1'b0, 3'b000, 3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
        step("post1", 1'b1, 3'b000, 3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
        step("post2", 1'b0, 3'b000, 3'b000, 1'b1, 3'b000, 3'b000, 1'b0, 1'b0);
        step("postG", 1'b1, 3'b010, 3'b000, 1'b1, 3'b010, 3'b000, 1'b0, 1'b1);
        step("postD", 1'b0, 3'b000, 3'b000, 1'b1, 3'b000, 3'b000, 1'b1, 1'b0);

        chk("scoreboard_empty", c_PW'(exp_q.size()), '0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/output_vc_arbiter.md
OUTPUT_VC_ARBITER -- requirements
Module: output_vc_arbiter

Interface
REQ-001 The module SHALL have parameter PACKET_WIDTH, default 64, which sets the packet data width in bits.
REQ-002 The module SHALL have parameter NUM_REQ, default 3, which sets the number of requesters: index 0 = cw, 1 = ccw, 2 = pe.
REQ-003 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 Port polarity, input, 1 bit: current router polarity (0 = even phase, 1 = odd phase).
REQ-006 Port req_even, input, NUM_REQ bits: per-requester request for the even virtual channel (VC0).
REQ-007 Port req_odd, input, NUM_REQ bits: per-requester request for the odd virtual channel (VC1).
REQ-008 Port req_data, input, NUM_REQ*PACKET_WIDTH bits: requester i's packet in bits [i*PACKET_WIDTH +: PACKET_WIDTH].
REQ-009 Port grant_even, output, NUM_REQ bits: one-hot, combinational; requester dequeues on the same rising edge.
REQ-010 Port grant_odd, output, NUM_REQ bits: one-hot, combinational; same rule as grant_even.
REQ-011 Port ri, input, 1 bit: downstream ready.
REQ-012 Port so, output, 1 bit: send strobe, registered.
REQ-013 Port dout, output, PACKET_WIDTH bits: registered output packet.

Function
REQ-014 The module SHALL hold one single-packet buffer per VC (buf[v], full[v]) and one round-robin pointer per VC (ptr[v], range 0..NUM_REQ-1).
REQ-015 Fill side: VC v = ~polarity is the fill VC; when full[v]=0 and req_v is nonzero, grant_v SHALL assert for exactly one requester, chosen by the first set bit of req_v searching ptr[v], ptr[v]+1, ... modulo NUM_REQ.
REQ-016 On the rising edge with grant_v[i]=1, the module SHALL set buf[v] to requester i's slice, set full[v] to 1, and set ptr[v] to (i+1) mod NUM_REQ.
REQ-017 grant for VC = polarity, and grant for any VC with full=1, SHALL be 0.
REQ-018 Drain side: VC p = polarity is the drain VC; on the rising edge where full[p]=1 and ri=1, so SHALL become 1, dout SHALL become buf[p], and full[p] SHALL become 0.
REQ-019 Otherwise so SHALL become 0 and dout SHALL hold its value.
REQ-020 Latency: a packet granted in phase p SHALL appear on so/dout at the first rising edge in the following phase ~p where ri=1; minimum is 1 edge after polarity toggles.
REQ-021 ri=0 while full[p]=1: the buffer SHALL be held (no loss, no overwrite); no grant for that VC until it drains.
REQ-022 Fill and drain SHALL act on different VCs in the same cycle, so simultaneous fill and drain are always permitted.
REQ-023 Requests not granted SHALL be held by the requester; the arbiter SHALL never grant the same VC twice in one cycle.
REQ-024 Pointer wrap: a grant to index NUM_REQ-1 SHALL set ptr to 0.
REQ-025 A request deasserting without a grant SHALL have no effect on state.

Reset
REQ-026 While reset=0, the module SHALL asynchronously force full[0]=full[1]=0, ptr[0]=ptr[1]=0, so=0, dout=0, grant_even=0, grant_odd=0.
REQ-027 Reset asserted mid-operation SHALL discard buffered packets.
REQ-028 The first grant SHALL be possible in the first cycle with reset=1.

Verification
REQ-029 Release reset with polarity=1 and req_even=3'b111 (data A, B, C) -> grant_even=3'b001 that cycle; ptr[0]=1; after polarity=0 with ri=1, so=1 and dout=A for one cycle.
REQ-030 Hold req_even=3'b111 across 3 even-fill phases with ri=1 -> grants 001, 010, 100, then 001 again (wrap); dout sequence A, B, C.
REQ-031 Fill VC1 with D, then hold ri=0 for 4 odd phases -> so=0; grant_odd=0 throughout; D still present; set ri=1 in the next odd phase -> so=1, dout=D, with exactly one pulse.
REQ-032 req_even=3'b100 and req_odd=3'b001 with polarity toggling every cycle -> both VCs fill and drain alternately with no lost or duplicated packets; so toggles 0/1 as expected.
REQ-033 Assert reset=0 with both buffers full -> so=0, dout=0, and grants 0 immediately (asynchronously); after release, the old packets never appear.
